gray_ptr_decoder: RTL and testbench
===================================

Name: gray_ptr_decoder

Overview:
- Receiving end of a Gray-coded counter/pointer.
- Samples an externally generated Gray vector through a synchronizer chain and decodes it to binary.
- Flags each step's direction (up/down) and detects Gray-code violations (more than one bit changing between samples).
- Sits on the read side of pointer-crossing logic, opposite the binary-to-Gray encoder.

Parameters:
- VEC_W, 4, width of the Gray input and binary output; legal range 2..32.
- SYNC_STAGES, 2, number of synchronizer flops on gray_i; legal range 2..4.
- ERR_CNT_W, 8, width of the saturating violation counter.

Ports:
- clk  input  1  single clock; all flops rising-edge.
- reset  input  1  asynchronous, active-high reset.
- gray_i  input  VEC_W  Gray-coded value, may change asynchronously to clk.
- err_clr_i  input  1  synchronous clear of err_cnt_o (and of err_o when sticky).
- bin_o  output  VEC_W  registered binary decode of the synchronized Gray value.
- change_o  output  1  one-cycle pulse when bin_o takes a new value.
- dir_o  output  1  1 = last change was +1 (mod 2^VEC_W); 0 = -1 or not a ±1 step.
- err_o  output  1  violation indication.
- err_cnt_o  output  ERR_CNT_W  saturating count of violations.

Behaviour:
- Reset: asynchronous on reset=1. Every synchronizer stage, prev_gray, bin_o, change_o, dir_o, err_o and err_cnt_o go to 0 immediately. Outputs hold 0 until reset deasserts. Reset mid-operation discards all in-flight samples.
- Synchronizer:
  - gray_i passes through SYNC_STAGES flops; the last stage is gsync.
  - No logic between stages.
- Decode (combinational on gsync):
  - b[VEC_W-1] = gsync[VEC_W-1].
  - b[i] = b[i+1] ^ gsync[i], for i from VEC_W-2 down to 0.
- Compare:
  - prev_gray register holds the previous gsync value.
  - diff = gsync ^ prev_gray.
  - prev_gray <= gsync every cycle.
- Output register, updated every cycle when diff != 0:
  - bin_o <= b.
  - change_o <= 1.
  - dir_o <= 1 if b == bin_o + 1 (mod 2^VEC_W), else 0.
- No-change cycles (diff == 0): change_o <= 0; bin_o and dir_o hold.
- Latency: a stable gray_i change appears on bin_o/change_o exactly SYNC_STAGES+1 rising edges later.
- Violation:
  - Condition: popcount(diff) > 1.
  - bin_o still updates to the decoded value (decode is total).
  - dir_o <= 0.
  - err_o pulses for one cycle, aligned with change_o.
  - err_cnt_o increments and saturates at 2^ERR_CNT_W-1.
- Wrap-around: max-value Gray code (e.g. 1000 for VEC_W=4) to 0000 is a legal single-bit step. bin_o goes 15->0, dir_o=1, no error.
- err_clr_i:
  - Sets err_cnt_o to 0 on the next edge.
  - If a violation is detected in the same cycle, err_cnt_o <= 1 (the clear applies first, then the increment).
- First post-reset comparison is against prev_gray=0. A non-zero, multi-bit gray_i present at reset release is therefore counted as a violation.
- gray_i changing on consecutive cycles is legal; each cycle's diff is evaluated independently.

Optional Feature:
- Macro: GRAY_ERR_STICKY_EN.
- Defined: err_o is sticky.
  - Set by any violation.
  - Held until err_clr_i=1; cleared on the next edge.
  - A violation in the same cycle as err_clr_i leaves err_o=1.
- Undefined: err_o is a one-cycle pulse per violation; err_clr_i affects only err_cnt_o.
- err_cnt_o behaviour is identical in both builds.

Test Plan (VEC_W=4, SYNC_STAGES=2, ERR_CNT_W=8):
1. Assert reset mid-stream with bin_o=9 -> bin_o, change_o, dir_o, err_o, err_cnt_o read 0 in the same cycle without a clock edge; after release, gray_i=0000 gives no change_o.
2. gray_i 0000->0001, held -> exactly 3 edges later bin_o=1, change_o=1 for one cycle, dir_o=1, err_o=0.
3. Step gray_i through all 16 codes upward, 4 cycles each, including 1000->0000 -> bin_o runs 0..15 then 0. 16 change_o pulses, dir_o=1 throughout, err_cnt_o=0.
4. From gray 0011 (bin 2) step to 0001 -> bin_o=1, dir_o=0, err_o=0.
5. gray_i 0000->0011 (two bits) -> bin_o=2, change_o=1, dir_o=0, err_o pulses (sticky build: stays 1 until err_clr_i), err_cnt_o=1.
6. Inject 300 violations -> err_cnt_o stops at 255. Then pulse err_clr_i -> err_cnt_o=0. Then err_clr_i coincident with a violation -> err_cnt_o=1.

Source files
------------

// File: rtl/gray_ptr_decoder.sv
// Read-side Gray pointer receiver: synchronizes gray_i, decodes it to binary and flags step direction and violations.
// Optional build macro GRAY_ERR_STICKY_EN makes err_o sticky until err_clr_i.
module gray_ptr_decoder #(
  parameter int VEC_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [VEC_W-1:0]     gray_i,
  input  logic                 err_clr_i,
  output logic [VEC_W-1:0]     bin_o,
  output logic                 change_o,
  output logic                 dir_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  logic [VEC_W-1:0] sync_q [SYNC_STAGES];
  logic [VEC_W-1:0] gsync;
  logic [VEC_W-1:0] prev_gray;
  logic [VEC_W-1:0] diff;
  logic [VEC_W-1:0] bin_dec;
  logic [VEC_W-1:0] bin_inc;
  logic             changed;
  logic             violation;

  // Plain flop chain; gray_i may be mid-transition, so no logic sits between stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign gsync = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_dec = '0;
    for (int i = 0; i < VEC_W; i++) bin_dec[i] = ^(gsync >> i);
  end

  assign diff      = gsync ^ prev_gray;
  assign changed   = (diff != '0);
  assign violation = ((diff & (diff - 1'b1)) != '0);
  assign bin_inc   = bin_o + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_gray <= '0;
      bin_o     <= '0;
      change_o  <= 1'b0;
      dir_o     <= 1'b0;
    end else begin
      prev_gray <= gsync;
      change_o  <= changed;
      if (changed) begin
        bin_o <= bin_dec;
        dir_o <= (bin_dec == bin_inc) && !violation;
      end
    end
  end

  // A clear and a violation on the same edge leave the count at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_o <= '0;
    end else if (err_clr_i) begin
      err_cnt_o <= violation ? ERR_CNT_W'(1) : '0;
    end else if (violation && (err_cnt_o != ERR_MAX)) begin
      err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

`ifdef GRAY_ERR_STICKY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          err_o <= 1'b0;
    else if (violation) err_o <= 1'b1;
    else if (err_clr_i) err_o <= 1'b0;
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_o <= 1'b0;
    else       err_o <= violation;
  end
`endif

endmodule

// File: tb/tb_gray_ptr_decoder.sv
// Directed self-checking bench for gray_ptr_decoder (VEC_W=4, SYNC_STAGES=2, ERR_CNT_W=8).
// Expectations follow GRAY_ERR_STICKY_EN when the bench is built with it.
module tb_gray_ptr_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] gray_i;
  logic       err_clr_i;
  logic [3:0] bin_o;
  logic       change_o;
  logic       dir_o;
  logic       err_o;
  logic [7:0] err_cnt_o;

  int checks = 0;
  int errors = 0;

`ifdef GRAY_ERR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  gray_ptr_decoder #(.VEC_W(4), .SYNC_STAGES(2), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .gray_i    (gray_i),
    .err_clr_i (err_clr_i),
    .bin_o     (bin_o),
    .change_o  (change_o),
    .dir_o     (dir_o),
    .err_o     (err_o),
    .err_cnt_o (err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] g, input logic clr);
    gray_i    = g;
    err_clr_i = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    int pulses;
    int dir_bad;
    int k;
    logic [3:0] g;

    // Power-on reset and release with an idle all-zero pointer.
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    tick(3);
    reset = 1'b0;
    tick(4);
    checkOutput("por_bin", bin_o, 0);
    checkOutput("por_change", change_o, 0);

    // Jump to bin 9 (Gray 1101), then assert reset asynchronously mid-stream.
    applyStimulus(4'b1101, 1'b0);
    tick(3);
    checkOutput("pre_rst_bin9", bin_o, 9);
    checkOutput("pre_rst_cnt", err_cnt_o, 1);
    reset = 1'b1;
    #2;
    checkOutput("async_rst_bin", bin_o, 0);
    checkOutput("async_rst_change", change_o, 0);
    checkOutput("async_rst_dir", dir_o, 0);
    checkOutput("async_rst_err", err_o, 0);
    checkOutput("async_rst_cnt", err_cnt_o, 0);
    applyStimulus(4'b0000, 1'b0);
    tick(2);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (change_o) pulses++;
    end
    checkOutput("post_rst_no_change", pulses, 0);
    checkOutput("post_rst_bin", bin_o, 0);

    // Single step 0000 -> 0001: visible exactly three edges later.
    applyStimulus(4'b0001, 1'b0);
    tick(2);
    checkOutput("lat_edge2_change", change_o, 0);
    tick(1);
    checkOutput("lat_edge3_bin", bin_o, 1);
    checkOutput("lat_edge3_change", change_o, 1);
    checkOutput("lat_edge3_dir", dir_o, 1);
    checkOutput("lat_edge3_err", err_o, 0);
    tick(1);
    checkOutput("lat_edge4_change", change_o, 0);

    // Back to 0, then walk all 16 codes upward including the 1000 -> 0000 wrap.
    applyStimulus(4'b0000, 1'b0);
    tick(4);
    checkOutput("walk_start_bin", bin_o, 0);
    pulses  = 0;
    dir_bad = 0;
    for (int step = 1; step <= 16; step++) begin
      k = step % 16;
      g = 4'(k ^ (k >> 1));
      applyStimulus(g, 1'b0);
      for (int c = 0; c < 4; c++) begin
        tick(1);
        if (change_o) begin
          pulses++;
          if (dir_o !== 1'b1) dir_bad++;
        end
      end
      checkOutput("walk_bin", bin_o, k);
    end
    checkOutput("walk_pulses", pulses, 16);
    checkOutput("walk_dir_bad", dir_bad, 0);
    checkOutput("walk_cnt", err_cnt_o, 0);
    checkOutput("walk_err", err_o, 0);

    // Down step from Gray 0011 (bin 2) to 0001 (bin 1).
    applyStimulus(4'b0001, 1'b0);
    tick(4);
    applyStimulus(4'b0011, 1'b0);
    tick(4);
    checkOutput("down_pre_bin", bin_o, 2);
    applyStimulus(4'b0001, 1'b0);
    tick(3);
    checkOutput("down_bin", bin_o, 1);
    checkOutput("down_change", change_o, 1);
    checkOutput("down_dir", dir_o, 0);
    checkOutput("down_err", err_o, 0);

    // Two-bit violation 0000 -> 0011.
    applyStimulus(4'b0000, 1'b0);
    tick(4);
    applyStimulus(4'b0011, 1'b0);
    tick(3);
    checkOutput("viol_bin", bin_o, 2);
    checkOutput("viol_change", change_o, 1);
    checkOutput("viol_dir", dir_o, 0);
    checkOutput("viol_err", err_o, 1);
    checkOutput("viol_cnt", err_cnt_o, 1);
    tick(1);
    checkOutput("viol_err_after", err_o, STICKY);
    applyStimulus(4'b0011, 1'b1);
    tick(1);
    applyStimulus(4'b0011, 1'b0);
    checkOutput("clr_cnt", err_cnt_o, 0);
    checkOutput("clr_err", err_o, 0);

    // Back-to-back violations: toggle 0011 <-> 0000 every cycle.
    for (int i = 0; i < 100; i++) begin
      applyStimulus((i % 2 == 0) ? 4'b0000 : 4'b0011, 1'b0);
      tick(1);
    end
    tick(4);
    checkOutput("burst_cnt_100", err_cnt_o, 100);
    for (int i = 0; i < 200; i++) begin
      applyStimulus((i % 2 == 0) ? 4'b0000 : 4'b0011, 1'b0);
      tick(1);
    end
    tick(4);
    checkOutput("burst_cnt_sat", err_cnt_o, 255);
    applyStimulus(4'b0011, 1'b1);
    tick(1);
    applyStimulus(4'b0011, 1'b0);
    checkOutput("sat_clr_cnt", err_cnt_o, 0);

    // Clear coincident with a violation reaching the output register.
    applyStimulus(4'b0000, 1'b0);
    tick(2);
    applyStimulus(4'b0000, 1'b1);
    tick(1);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("coinc_cnt", err_cnt_o, 1);
    checkOutput("coinc_err", err_o, 1);
    tick(1);
    checkOutput("coinc_err_after", err_o, STICKY);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
